// File: rtl/seq_mult_core_if.sv
// Operand/result bundle between the start one-shot side and the
// shift-and-add multiplier core.
interface seq_mult_core_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/seq_mult_core.sv
// Unsigned shift-and-add multiplier: one partial-product step per clock,
// N steps per operation, registered 2N-bit product with a one-cycle done.
module seq_mult_core #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_core_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_areg;
  logic [N:0]     r_acc;
  logic [N-1:0]   r_qreg;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;
  logic           r_busy;
  logic           r_done;

  state_t         w_state_next;
  logic [N-1:0]   w_areg_next;
  logic [N:0]     w_acc_next;
  logic [N-1:0]   w_qreg_next;
  logic [CW-1:0]  w_count_next;
  logic [2*N-1:0] w_product_next;
  logic           w_busy_next;
  logic           w_done_next;
  logic [N:0]     w_addend;
  logic [N:0]     w_sum;
  logic           w_last;

  // acc never exceeds 2^N-1 after a shift, so an N+1 bit sum cannot overflow
  assign w_addend = r_qreg[0] ? {1'b0, r_areg} : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_last   = (r_count == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_areg    <= '0;
      r_acc     <= '0;
      r_qreg    <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_areg    <= w_areg_next;
      r_acc     <= w_acc_next;
      r_qreg    <= w_qreg_next;
      r_count   <= w_count_next;
      r_product <= w_product_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_areg_next    = r_areg;
    w_acc_next     = r_acc;
    w_qreg_next    = r_qreg;
    w_count_next   = r_count;
    w_product_next = r_product;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_next = 1'b0;
        if (bus.start) begin
          w_areg_next  = bus.multiplicand;
          w_qreg_next  = bus.multiplier;
          w_acc_next   = '0;
          w_count_next = '0;
          w_busy_next  = 1'b1;
          w_state_next = S_CALC;
        end
      end

      S_CALC: begin
        // {acc,qreg} <= {sum,qreg} >> 1
        w_acc_next   = {1'b0, w_sum[N:1]};
        w_qreg_next  = {w_sum[0], r_qreg[N-1:1]};
        w_count_next = r_count + 1'b1;
        if (w_last) begin
          w_product_next = {w_sum[N:1], w_sum[0], r_qreg[N-1:1]};
          w_done_next    = 1'b1;
          w_state_next   = S_DONE;
        end
      end

      S_DONE: begin
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.product = r_product;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_seq_mult_core.sv
// Directed bench for seq_mult_core: expected products go into a scoreboard
// queue, a monitor pops and compares on every done strobe.
module tb_seq_mult_core;
  localparam int N = 8;

  logic clk;
  logic rst;

  seq_mult_core_if #(.N(N)) bus ();

  seq_mult_core #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int seen_done = 0;
  logic [2*N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      logic [2*N-1:0] exp;
      seen_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.product), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        chk("product", 32'(bus.product), 32'(exp));
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        $display("result product=%0d expected=%0d", bus.product, exp);
      end
    end
  end

  // mode 0: plain, 1: extra start pulse during CALC, 2: scramble operands during CALC
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] want, input int mode);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    exp_q.push_back(want);
    pushed++;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("done_after_accept", 32'(bus.done), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (mode == 1 && i == 3) begin
        bus.multiplicand = 8'd7;
        bus.multiplier   = 8'd7;
        bus.start        = 1'b1;
      end
      if (mode == 2) begin
        bus.multiplicand = 8'($urandom);
        bus.multiplier   = 8'($urandom);
      end
      if (i == 7) chk("done_early", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk("done_at_k+N", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("busy_cleared", 32'(bus.busy), 32'd0);
    chk("product_held", 32'(bus.product), 32'(want));
    $display("op a=%0d b=%0d mode=%0d expect=%0d", a, b, mode, want);
  endtask

  initial begin
    int done_cyc[$];
    rst = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    chk("reset_product", 32'(bus.product), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'd3,   8'd5,   16'd15,    0);
    run_op(8'd255, 8'd255, 16'd65025, 0);
    run_op(8'd0,   8'd200, 16'd0,     0);
    run_op(8'd1,   8'd128, 16'd128,   0);
    run_op(8'd12,  8'd11,  16'd132,   1);
    repeat (12) @(negedge clk);
    chk("no_second_done_count", 32'(seen_done), 32'd5);
    chk("idle_product_132", 32'(bus.product), 32'd132);

    run_op(8'd20, 8'd13, 16'd260, 2);

    // start held high for 30 cycles
    @(negedge clk);
    bus.multiplicand = 8'd6;
    bus.multiplier   = 8'd9;
    bus.start        = 1'b1;
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(16'd54);
      pushed++;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cyc.push_back(c);
      if (done_cyc.size() > 0) chk("hold_product_54", 32'(bus.product), 32'd54);
    end
    bus.start = 1'b0;
    chk("hold_done_count", 32'(done_cyc.size()), 32'd3);
    for (int j = 1; j < done_cyc.size(); j++)
      chk("hold_done_gap", 32'(done_cyc[j] - done_cyc[j-1]), 32'(N + 2));
    if (done_cyc.size() > 0) chk("hold_first_done", 32'(done_cyc[0]), 32'(N));
    repeat (3) @(negedge clk);

    // asynchronous reset mid-CALC, operation aborted
    @(negedge clk);
    bus.multiplicand = 8'd15;
    bus.multiplier   = 8'd15;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_product", 32'(bus.product), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    run_op(8'd10, 8'd10, 16'd100, 0);

    repeat (12) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_total", 32'(seen_done), 32'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
Unsigned shift-and-add multiplier datapath and control FSM. It sits directly downstream of the start one-shot and consumes its single-cycle start pulse. It latches two N-bit operands and iterates one partial-product step per clock. It presents a 2N-bit registered product with a one-cycle done strobe. The product is held until the next completion.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle start pulse from the one-shot; sampled only in IDLE
multiplicand  input  N  operand A, unsigned, sampled on the accepting edge
multiplier  input  N  operand B, unsigned, sampled on the accepting edge
product  output  2N  registered result A*B, held until the next completion
busy  output  1  high from the accepting edge until the done cycle ends
done  output  1  one-cycle strobe; product is valid and newly updated

Behaviour:
- Reset is asynchronous: rst=0 forces state=IDLE, product=0, busy=0, done=0, internal registers and count=0, immediately and regardless of clk.
- Reset mid-operation aborts the computation and leaves no partial result visible.
- Internal registers: areg (N bits), acc (N+1 bits, carry-extended upper half), qreg (N bits, lower half / multiplier), count of width clog2(N+1).
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: areg<=multiplicand, qreg<=multiplier, acc<=0, count<=0, busy<=1, state<=CALC.
- CALC (exactly N cycles):
  - Each edge: sum = acc + (qreg[0] ? areg : 0), computed N+1 bits wide with no overflow loss.
  - Then {acc,qreg} <= {sum,qreg} >> 1 (logical); count<=count+1.
  - When count==N-1 at an edge, that final iteration completes and state<=DONE.
  - On that same edge: product<={final acc[N-1:0], final qreg}, done<=1.
- DONE (one cycle):
  - done=1, busy=1, product valid.
  - Next edge: done<=0, busy<=0, state<=IDLE.
- Latency: start accepted at edge k → product updated and done=1 after edge k+N; IDLE again after edge k+N+1.
- Back-to-back operations: the next start is accepted no earlier than edge k+N+2, giving a throughput of one result per N+2 cycles.
- start while in CALC or DONE is ignored: no restart and no queuing.
- start held high for multiple cycles re-triggers only once the FSM returns to IDLE. The one-shot normally prevents this case.
- Operands may change after the accepting edge without effect on the running computation.
- product holds its last value through IDLE and CALC. It changes only on the completion edge or on reset.
- Arithmetic is unsigned. Maximum result (2^N-1)^2 fits in 2N bits; no overflow flag.
- An illegal or unused state encoding returns to IDLE on the next edge with busy=0, done=0.

Test Plan:
- Reset, then N=8, A=3, B=5, start pulse at edge k → busy=1 from edge k; done=1 exactly in cycle after edge k+8; product=16'd15; busy=0 after edge k+9.
- A=255, B=255 → product=16'd65025 (0xFE01); A=0, B=200 → product=0; A=1, B=128 → product=128; done asserts once per operation.
- Run A=12, B=11, then pulse start again with A=7, B=7 during CALC → second start ignored; product=132; no second done until a new start in IDLE.
- Hold start high continuously for 30 cycles with A=6, B=9 → one result 54 per 10-cycle period; done strobes are separated by exactly N+2=10 cycles; product stays 54 between strobes.
- Assert rst=0 mid-CALC (4 cycles after start), asynchronously between edges → product, busy and done go to 0 immediately; after release, a new start with A=10, B=10 gives product=100 with normal latency.
- Change multiplicand/multiplier inputs every cycle during CALC after launching A=20, B=13 → product=260 (operands latched at start).
